// File: rtl/mem_port_arbiter_if.sv
// MemPort bundle: valid/ready request handshake plus in-order rvalid responses.
// The master drives the request fields; the slave drives ready and the response.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic                  write_en;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     wdata;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, addr, write_en, byte_en, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, write_en, byte_en, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one MemPort slave between instruction and data masters, routing in-order
// responses through an ID FIFO. Define MEM_ARB_ROUND_ROBIN_EN to alternate on ties.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    instr,
  mem_port_arbiter_if.slave    data,
  mem_port_arbiter_if.master   mem,
  output logic                 err
);

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } id_e;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  id_e           r_ids [MAX_OUTSTANDING];
  logic [CW-1:0] r_count;
  logic          r_lock_vld;
  id_e           r_lock_id;
  id_e           r_last_id;
  logic          r_err;

  id_e           w_sel;
  logic          w_sel_valid;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_pop;
  logic          w_rsp_err;
  logic [IW-1:0] w_wr_idx;

  always_comb begin
    w_sel = ID_DATA;
    if (r_lock_vld) begin
      w_sel = r_lock_id;
    end else if (instr.valid && !data.valid) begin
      w_sel = ID_INSTR;
    end else if (data.valid && !instr.valid) begin
      w_sel = ID_DATA;
    end else if (instr.valid && data.valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_sel = id_e'(~r_last_id);
`else
      w_sel = ID_DATA;
`endif
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never unblocks.
  assign w_full      = (r_count == MAX_CNT);
  assign w_empty     = (r_count == '0);
  assign w_sel_valid = (w_sel == ID_DATA) ? data.valid : instr.valid;
  assign w_accept    = mem.valid & mem.ready;

  assign mem.valid    = w_sel_valid & ~w_full & ~rst;
  assign mem.addr     = (w_sel == ID_DATA) ? data.addr : instr.addr;
  assign mem.write_en = (w_sel == ID_DATA) & data.write_en;
  assign mem.byte_en  = (w_sel == ID_DATA) ? data.byte_en : '1;
  assign mem.wdata    = (w_sel == ID_DATA) ? data.wdata : '0;

  assign instr.ready  = w_accept & (w_sel == ID_INSTR);
  assign data.ready   = w_accept & (w_sel == ID_DATA);

  assign w_pop        = mem.rvalid & ~w_empty & ~rst;
  assign w_rsp_err    = mem.rvalid & w_empty;
  assign instr.rvalid = w_pop & (r_ids[0] == ID_INSTR);
  assign data.rvalid  = w_pop & (r_ids[0] == ID_DATA);
  assign instr.rdata  = mem.rdata;
  assign data.rdata   = mem.rdata;
  assign err          = r_err;

  // On a simultaneous pop the entries shift down, so the new ID lands one slot lower.
  assign w_wr_idx = w_pop ? IW'(r_count - 1'b1) : IW'(r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ids      <= '{default: ID_INSTR};
      r_count    <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= ID_INSTR;
      r_last_id  <= ID_INSTR;
      r_err      <= 1'b0;
    end else begin
      if (w_pop) begin
        for (int unsigned i = 0; i + 1 < MAX_OUTSTANDING; i++) begin
          r_ids[i] <= r_ids[i+1];
        end
      end
      if (w_accept) begin
        r_ids[w_wr_idx] <= w_sel;
        r_last_id       <= w_sel;
      end

      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (w_accept) begin
        r_lock_vld <= 1'b0;
      end else if (mem.valid && !mem.ready) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_sel;
      end

      if (w_rsp_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Instruction ports carry no write fields; last_id only steers round-robin builds.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic w_unused;
  assign w_unused = ^{instr.write_en, instr.byte_en, instr.wdata};
`else
  logic w_unused;
  assign w_unused = ^{instr.write_en, instr.byte_en, instr.wdata, r_last_id};
`endif

endmodule
